ltl_monitor_sequencer: RTL and testbench
========================================

// Module: ltl_monitor_sequencer
// PURPOSE
//  Sequences one LTL automata cluster (e.g. Automata_ltl2c<N>). It takes a trace-symbol stream over valid/ready
//  and drives the cluster's reset/run/symbols pins. It guarantees the cluster's start-of-data window coincides
//  with the first symbol. It captures non-zero report vectors, tagged with the symbol index, into a report FIFO.
//  Sits between the core trace tap and the monitor report collector.
// PARAMETERS
//  SYM_W        8   symbol width; must equal the cluster symbol width
//  N_RPT        4   number of cluster report outputs (am_report width)
//  FIFO_DEPTH   4   report FIFO entries; power of two, >=2
//  IDX_W        16  symbol index counter width; wraps modulo 2^IDX_W
//  INIT_CYCLES  2   minimum cycles am_reset is held in INIT; >=1
// PORTS
//  clk         in   1          clock; all state updates on posedge
//  reset       in   1          asynchronous, active-high reset
//  start       in   1          pulse: begin a new trace; honoured only in IDLE
//  stop        in   1          pulse: end of trace; honoured only in RUN
//  sym_valid   in   1          trace symbol valid
//  sym_data    in   SYM_W      trace symbol
//  sym_ready   out  1          symbol accepted when sym_valid & sym_ready
//  am_reset    out  1          to cluster reset
//  am_run      out  1          to cluster run
//  am_symbols  out  SYM_W      to cluster symbols
//  am_report   in   N_RPT      cluster report outputs, concatenated
//  rpt_valid   out  1          report FIFO head valid
//  rpt_ready   in   1          consumer pops head when rpt_valid & rpt_ready
//  rpt_vec     out  N_RPT      head report vector
//  rpt_idx     out  IDX_W      head symbol index
//  busy        out  1          state != IDLE
// BEHAVIOUR
//  FSM: IDLE -> INIT -> ARM -> RUN -> DRAIN -> IDLE. Reset state IDLE.
//  Values after reset: am_reset=1, sym_ready=0, am_run=0, rpt_valid=0, busy=0, FIFO empty, idx=0.
//  IDLE:
//   - am_reset=1, sym_ready=0.
//   - start=1 -> INIT. Entering INIT clears the FIFO, idx, rep_pend and the INIT counter.
//  INIT:
//   - am_reset=1 for exactly INIT_CYCLES cycles, then -> ARM.
//  ARM:
//   - am_reset=1, sym_ready=0.
//   - When sym_valid=1 -> RUN; am_reset is registered low on that edge.
//   - The cluster start-of-data pulse therefore lands in the first RUN cycle, while the held symbol is accepted.
//   - Producers must hold sym_valid/sym_data until accepted (standard valid/ready).
//  RUN:
//   - am_reset=0.
//   - sym_ready = (fifo_count + rep_pend) < FIFO_DEPTH, where rep_pend = a symbol was accepted in the previous cycle.
//   - am_run = sym_valid & sym_ready; am_symbols = sym_data. Both are combinational, zero latency.
//   - am_run=0 while no symbol is accepted; the cluster holds its state.
//   - Each accepted symbol latches idx_q<=idx, sets rep_pend<=1, and increments idx (wraps 2^IDX_W-1 -> 0).
//   - stop=1 -> DRAIN. A symbol accepted in the same cycle as stop is the last symbol and is processed.
//  Report capture (RUN and DRAIN):
//   - In the cycle after acceptance (rep_pend=1), if |am_report, push {am_report, idx_q}.
//   - All-zero report vectors are discarded.
//   - The FIFO cannot overflow by construction; a push while full is an assertion failure.
//   - Push and pop in the same cycle are both honoured; the count is unchanged.
//  DRAIN:
//   - sym_ready=0, am_run=0, am_reset=0.
//   - Lasts one cycle (the final capture), then -> IDLE. The FIFO is retained for the consumer.
//  FIFO:
//   - FWFT; rpt_vec/rpt_idx are valid whenever rpt_valid=1 and stable until popped.
//   - rpt_ready while empty has no effect.
//  Ignored inputs:
//   - start outside IDLE is ignored.
//   - stop outside RUN is ignored.
//  Reset mid-operation:
//   - Asynchronously returns to IDLE, empties the FIFO and forces am_reset=1 immediately.
// TESTING
//  - Reset: assert reset mid-RUN with 2 FIFO entries -> am_reset=1, rpt_valid=0, busy=0 before the next edge.
//  - Start window: start; sym_valid raised 5 cycles after ARM entry -> am_reset stays 1 until ARM sees valid.
//    The first accepted symbol coincides with cluster start_of_data=1; am_run=1 that cycle.
//  - Indexing: 3 symbols, am_report=4'b0010 after the 2nd only -> one entry {vec=4'b0010, idx=1}.
//  - Backpressure: FIFO_DEPTH=4, rpt_ready=0, report on every symbol -> exactly 4 accepted, then sym_ready=0.
//    One pop -> exactly one more symbol is accepted.
//  - Stop with last symbol: stop and an accepted symbol in the same cycle -> its report is captured in DRAIN.
//    FSM returns to IDLE one cycle later.
//  - Wrap: IDX_W=4, 18 reporting symbols, continuous pops -> idx sequence 0..15,0,1.
//    Simultaneous push/pop keeps count constant.

Source files
------------

// File: rtl/ltl_monitor_sequencer.sv
// Sequences one LTL automata cluster: reset window, symbol feed, and tagged report capture.
// Non-zero report vectors are queued with the index of the symbol that produced them.
module ltl_monitor_sequencer #(
  parameter int SYM_W       = 8,
  parameter int N_RPT       = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDX_W       = 16,
  parameter int INIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_data,
  output logic             sym_ready,
  output logic             am_reset,
  output logic             am_run,
  output logic [SYM_W-1:0] am_symbols,
  input  logic [N_RPT-1:0] am_report,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [N_RPT-1:0] rpt_vec,
  output logic [IDX_W-1:0] rpt_idx,
  output logic             busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ICW   = $clog2(INIT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ARM, S_RUN, S_DRAIN} state_t;
  typedef struct packed {
    logic [N_RPT-1:0] vec;
    logic [IDX_W-1:0] idx;
  } rpt_t;

  state_t           state;
  logic [ICW-1:0]   init_cnt;
  logic [IDX_W-1:0] idx, idx_q;
  logic             rep_pend;
  rpt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ;
  logic             accept, push, pop;

  // A symbol in flight reserves a FIFO slot, so a full FIFO can never be pushed.
  assign occ       = {1'b0, count} + {{CNT_W{1'b0}}, rep_pend};
  assign sym_ready = (state == S_RUN) && (occ < (CNT_W+1)'(FIFO_DEPTH));
  assign accept    = sym_valid & sym_ready;
  assign am_run    = accept;
  assign am_symbols = sym_data;
  assign push      = ((state == S_RUN) || (state == S_DRAIN)) && rep_pend && (|am_report);
  assign rpt_valid = (count != '0);
  assign pop       = rpt_valid & rpt_ready;
  assign rpt_vec   = mem[rd_ptr].vec;
  assign rpt_idx   = mem[rd_ptr].idx;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      am_reset <= 1'b1;
      init_cnt <= '0;
      idx      <= '0;
      idx_q    <= '0;
      rep_pend <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      rep_pend <= accept;
      if (accept) begin
        idx_q <= idx;
        idx   <= idx + IDX_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);

      case (state)
        S_IDLE: begin
          am_reset <= 1'b1;
          if (start) begin
            state    <= S_INIT;
            init_cnt <= '0;
            idx      <= '0;
            rep_pend <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
          end
        end
        S_INIT: begin
          if (init_cnt == ICW'(INIT_CYCLES - 1)) state <= S_ARM;
          else init_cnt <= init_cnt + ICW'(1);
        end
        // Dropping am_reset on the edge that sees valid puts start-of-data on the first accept.
        S_ARM: begin
          if (sym_valid) begin
            state    <= S_RUN;
            am_reset <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) state <= S_DRAIN;
        end
        S_DRAIN: begin
          state    <= S_IDLE;
          am_reset <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          am_reset <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{vec: am_report, idx: idx_q};
      assert (count != CNT_W'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_ltl_monitor_sequencer.sv
// Randomized scoreboard bench: the bench plays the automata cluster and predicts tagged reports.
module tb_ltl_monitor_sequencer;

  logic       clk, reset, start, stop, sym_valid, sym_ready;
  logic [7:0] sym_data, am_symbols;
  logic       am_reset, am_run, rpt_valid, rpt_ready, busy;
  logic [3:0] am_report, rpt_vec, rpt_idx;

  ltl_monitor_sequencer #(.SYM_W(8), .N_RPT(4), .FIFO_DEPTH(4), .IDX_W(4), .INIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .am_reset(am_reset), .am_run(am_run), .am_symbols(am_symbols), .am_report(am_report),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_vec(rpt_vec), .rpt_idx(rpt_idx),
    .busy(busy)
  );

  typedef struct packed { logic [3:0] vec; logic [3:0] idx; } exp_t;

  exp_t       exp_q[$];
  logic [7:0] sym_src[$];
  int         errors = 0, checks = 0;
  int         rep_mode = 0, m_idx = 0;
  bit         in_run = 0, pend = 0, pend_rep = 0;
  logic [7:0] last_sym = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cluster behaviour: the report a symbol produces, by test mode.
  function automatic logic [3:0] fn(input logic [7:0] s);
    case (rep_mode)
      0:       return 4'h0;
      1:       return s[3:0];
      default: return (s[3:0] == 4'h0) ? 4'h8 : s[3:0];
    endcase
  endfunction

  // Cluster model: report follows the accepted symbol by one cycle; junk otherwise.
  always @(negedge clk) am_report = pend ? fn(last_sym) : 4'($urandom);

  // Acceptance tracker: predicts readiness and pushes expected reports.
  always @(negedge clk) begin
    bit         acc, exp_ready;
    logic [3:0] v;
    #3;
    if (reset) begin
      pend = 0; pend_rep = 0;
    end else begin
      exp_ready = in_run && ((exp_q.size() + ((pend && !pend_rep) ? 1 : 0)) < 4);
      chk("sym_ready", sym_ready, exp_ready);
      chk("am_run", am_run, sym_valid && exp_ready);
      if (am_run) chk("am_symbols", am_symbols, sym_data);
      acc = sym_valid && sym_ready;
      pend = acc; pend_rep = 0;
      if (acc) begin
        v = fn(sym_data);
        last_sym = sym_data;
        if (v != 4'h0) begin
          exp_q.push_back('{vec: v, idx: 4'(m_idx)});
          pend_rep = 1;
        end
        m_idx = (m_idx + 1) % 16;
      end
    end
  end

  // Report monitor: compares each popped FIFO head against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (!reset && rpt_valid && rpt_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rpt_unexpected: got vec=%0h idx=%0h expected none", rpt_vec, rpt_idx);
      end else begin
        e = exp_q.pop_front();
        chk("rpt_vec", rpt_vec, e.vec);
        chk("rpt_idx", rpt_idx, e.idx);
      end
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1; exp_q.delete(); m_idx = 0;
    @(negedge clk); start = 0;
    #1 chk("init_busy", busy, 1); chk("init_am_reset", am_reset, 1);
    @(negedge clk);
  endtask

  task automatic end_trace(input bit stopped);
    if (!stopped) begin
      @(negedge clk); sym_valid = 0; stop = 1;
    end
    @(negedge clk); stop = 0; sym_valid = 0; in_run = 0;
    #1 chk("drain_busy", busy, 1); chk("drain_am_reset", am_reset, 0);
    @(negedge clk);
    #1 chk("idle_busy", busy, 0); chk("idle_am_reset", am_reset, 1);
  endtask

  task automatic pop_all();
    repeat (8) begin @(negedge clk); rpt_ready = 1; end
    @(negedge clk); rpt_ready = 0;
    #1 chk("drained_q", exp_q.size(), 0); chk("drained_valid", rpt_valid, 0);
  endtask

  // Feeds n symbols starting in ARM; optional gap before the first valid.
  task automatic trace(input int n, input int gap, input bit rand_valid, input int pop_mode,
                       input bit stop_last, input bit finish, output int run_cycles);
    int acc_cnt = 0, g = gap;
    bit hold = 0, started = 0, first;
    run_cycles = 0;
    for (int guard = 0; guard < 2000 && acc_cnt < n; guard++) begin
      @(negedge clk);
      first = 0;
      if (started && !in_run) begin in_run = 1; first = 1; end
      rpt_ready = (pop_mode == 1) ? 1'b1 : (pop_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!hold) begin
        if (!in_run && g > 0) begin sym_valid = 0; g--; end
        else begin
          sym_valid = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (sym_valid) sym_data = (sym_src.size() > 0) ? sym_src.pop_front() : 8'($urandom);
        end
      end
      #1;
      if (in_run) run_cycles++;
      if (!in_run) chk("arm_am_reset", am_reset, 1);
      if (first) begin chk("sod_am_reset", am_reset, 0); chk("sod_am_run", am_run, 1); end
      if (in_run && sym_valid && sym_ready) begin
        acc_cnt++; hold = 0;
        if (stop_last && acc_cnt == n) stop = 1;
      end else hold = sym_valid;
      if (sym_valid && !in_run) started = 1;
    end
    if (acc_cnt < n) begin
      checks++; errors++;
      $display("FAIL trace_timeout: got %0d accepted expected %0d", acc_cnt, n);
    end
    rpt_ready = 0;
    if (finish) end_trace(stop_last);
  endtask

  initial begin
    int rc, extra;
    clk = 0; reset = 1; start = 0; stop = 0; sym_valid = 0; sym_data = 0; rpt_ready = 0;
    repeat (3) @(negedge clk);
    #1 chk("rst_am_reset", am_reset, 1); chk("rst_sym_ready", sym_ready, 0);
    chk("rst_am_run", am_run, 0); chk("rst_rpt_valid", rpt_valid, 0); chk("rst_busy", busy, 0);
    @(negedge clk); reset = 0;
    #1 chk("post_rst_busy", busy, 0); chk("post_rst_am_reset", am_reset, 1);

    // start window with a 5-cycle gap; only the second symbol reports
    do_start(); rep_mode = 1; sym_src = '{8'h00, 8'h02, 8'h00};
    trace(3, 5, 0, 0, 0, 1, rc);
    pop_all();

    // backpressure: no pops, every symbol reports
    do_start(); rep_mode = 2;
    trace(4, 0, 0, 0, 0, 0, rc);
    extra = 0;
    repeat (4) begin
      @(negedge clk); sym_valid = 1; sym_data = 8'h11; rpt_ready = 0;
      #1 if (sym_ready) extra++;
    end
    chk("bp_full", extra, 0);
    @(negedge clk); rpt_ready = 1;
    #1 if (sym_ready) extra++;
    repeat (4) begin
      @(negedge clk); rpt_ready = 0;
      #1 if (sym_ready) extra++;
    end
    chk("bp_one_more", extra, 1);
    end_trace(0);
    pop_all();

    // stop coincides with the last accepted symbol
    do_start(); rep_mode = 2;
    trace(2, 0, 0, 0, 1, 1, rc);
    pop_all();

    // index wrap with continuous pops: full throughput
    do_start(); rep_mode = 2;
    trace(18, 0, 0, 1, 1, 1, rc);
    chk("wrap_run_cycles", rc, 18);
    pop_all();

    // randomized traces
    for (int t = 0; t < 4; t++) begin
      do_start(); rep_mode = 1;
      trace(30, $urandom_range(0, 3), 1, 2, 1'($urandom_range(0, 1)), 1, rc);
      pop_all();
    end

    // asynchronous reset mid-RUN with two queued reports
    do_start(); rep_mode = 2;
    trace(2, 0, 0, 0, 0, 0, rc);
    @(negedge clk); sym_valid = 0;
    @(negedge clk);
    #1 chk("pre_rst_rpt_valid", rpt_valid, 1); chk("pre_rst_am_reset", am_reset, 0);
    reset = 1;
    #1 chk("mid_rst_am_reset", am_reset, 1); chk("mid_rst_rpt_valid", rpt_valid, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete(); in_run = 0;
    @(negedge clk); reset = 0;

    // recovery after reset
    do_start(); rep_mode = 1;
    trace(10, 1, 1, 2, 0, 1, rc);
    pop_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
